// File: rtl/hazard_controller.sv
// hazard_controller: central stall/flush sequencer for the 5-stage ARM pipeline.
// Decides per cycle whether each pipeline register advances, holds or is
// squashed, produces EX-stage forwarding selects, keeps stall/flush statistics
// and runs a data-memory wait FSM with a sticky timeout watchdog.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_ra1,
  input  logic [3:0]       id_ra2,
  input  logic             id_use_ra1,
  input  logic             id_use_ra2,
  input  logic [3:0]       ex_ra1,
  input  logic [3:0]       ex_ra2,
  input  logic [3:0]       ex_wa,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic             ex_branch_taken,
  input  logic [3:0]       mem_wa,
  input  logic             mem_reg_write,
  input  logic [3:0]       wb_wa,
  input  logic             wb_reg_write,
  input  logic             dmem_busy,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_enable,
  output logic             cu_bubble,
  output logic             ex_mem_enable,
  output logic             mem_wb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_TIMEOUT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic [CNT_W-1:0]   flush_count_q, flush_count_d;
  logic               load_use;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // MEM result is newer than WB, so it wins; R15 (PC) is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic [3:0] m_wa, input logic m_we,
    input logic [3:0] w_wa, input logic w_we
  );
    if (m_we && (m_wa == ra) && (m_wa != 4'd15))      return 2'b10;
    else if (w_we && (w_wa == ra) && (w_wa != 4'd15)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  // A load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = ex_mem_to_reg && ex_reg_write &&
               ((id_use_ra1 && (ex_wa == id_ra1)) ||
                (id_use_ra2 && (ex_wa == id_ra2)));
  end

  // Next-state, statistics and zero-latency pipeline control outputs.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b1;
    cu_bubble     = 1'b0;
    ex_mem_enable = 1'b1;
    mem_wb_bubble = 1'b0;
    fwd_a         = 2'b00;
    fwd_b         = 2'b00;

    if (reset) begin
      fwd_a = fwd_sel(ex_ra1, mem_wa, mem_reg_write, wb_wa, wb_reg_write);
      fwd_b = fwd_sel(ex_ra2, mem_wa, mem_reg_write, wb_wa, wb_reg_write);

      if (state_q == S_TIMEOUT || dmem_busy) begin
        // Freeze: hold everything up to EX/MEM, drop the write in MEM/WB.
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_bubble = 1'b1;
        if (state_q != S_TIMEOUT) begin
          wait_cnt_d    = (state_q == S_RUN) ? WAIT_ONE : wait_cnt_q + WAIT_ONE;
          stall_count_d = sat_inc(stall_count_q);
          if (wait_cnt_d >= WAIT_LIMIT) begin
            state_d       = S_TIMEOUT;
            mem_timeout_d = 1'b1;
          end else begin
            state_d = S_MEM_WAIT;
          end
        end
      end else begin
        // Memory ready: this cycle follows RUN rules whatever the wait state.
        state_d    = S_RUN;
        wait_cnt_d = '0;
        if (ex_branch_taken) begin
          if_id_flush   = 1'b1;
          cu_bubble     = 1'b1;
          flush_count_d = sat_inc(flush_count_q);
        end else if (load_use) begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          cu_bubble     = 1'b1;
          stall_count_d = sat_inc(stall_count_q);
        end
      end
    end
  end

  // State, watchdog and statistics registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // The sticky flag and counters are visible straight from their registers.
  always_comb begin
    mem_timeout = mem_timeout_q;
    stall_count = stall_count_q;
    flush_count = flush_count_q;
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios with constant
// expectations plus randomized traffic checked against a behavioural model.
module tb_hazard_controller;

  localparam int TMO   = 4;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    id_ra1, id_ra2, ex_ra1, ex_ra2, ex_wa, mem_wa, wb_wa;
  logic          id_use_ra1, id_use_ra2, ex_reg_write, ex_mem_to_reg;
  logic          ex_branch_taken, mem_reg_write, wb_reg_write, dmem_busy;
  logic          pc_enable, if_id_enable, if_id_flush, id_ex_enable;
  logic          cu_bubble, ex_mem_enable, mem_wb_bubble, mem_timeout;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_count, flush_count;

  hazard_controller #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_ra1(id_ra1), .id_ra2(id_ra2), .id_use_ra1(id_use_ra1), .id_use_ra2(id_use_ra2),
    .ex_ra1(ex_ra1), .ex_ra2(ex_ra2), .ex_wa(ex_wa), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch_taken(ex_branch_taken),
    .mem_wa(mem_wa), .mem_reg_write(mem_reg_write), .wb_wa(wb_wa), .wb_reg_write(wb_reg_write),
    .dmem_busy(dmem_busy),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .id_ex_enable(id_ex_enable), .cu_bubble(cu_bubble), .ex_mem_enable(ex_mem_enable),
    .mem_wb_bubble(mem_wb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: pipeline mode (0 running, 1 waiting on memory, 2 dead),
  // consecutive busy cycles seen, sticky flag and plain integer counters.
  int m_mode, m_busy_run, m_stall, m_flush;
  bit m_to;
  bit e_pc, e_ifid, e_flush, e_idex, e_bub, e_exmem, e_mwb;
  int e_fa, e_fb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int fwd_model(input logic [3:0] ra);
    if (mem_reg_write && mem_wa == ra && mem_wa != 4'd15) return 2;
    if (wb_reg_write && wb_wa == ra && wb_wa != 4'd15) return 1;
    return 0;
  endfunction

  function automatic bit is_load_use();
    return ex_mem_to_reg && ex_reg_write &&
           ((id_use_ra1 && ex_wa == id_ra1) || (id_use_ra2 && ex_wa == id_ra2));
  endfunction

  task automatic model_reset();
    m_mode = 0; m_busy_run = 0; m_to = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic predict();
    {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
    {e_flush, e_bub, e_mwb} = 3'b000;
    e_fa = 0; e_fb = 0;
    if (!reset) begin
      model_reset();
      return;
    end
    e_fa = fwd_model(ex_ra1);
    e_fb = fwd_model(ex_ra2);
    if (m_mode == 2 || dmem_busy) begin
      {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
      e_mwb = 1;
    end else if (ex_branch_taken) begin
      e_flush = 1; e_bub = 1;
    end else if (is_load_use()) begin
      e_pc = 0; e_ifid = 0; e_bub = 1;
    end
  endtask

  task automatic model_clock();
    if (!reset) begin
      model_reset();
    end else if (m_mode != 2) begin
      if (dmem_busy) begin
        m_busy_run++;
        m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (m_busy_run >= TMO) begin m_mode = 2; m_to = 1; end
        else m_mode = 1;
      end else begin
        m_busy_run = 0;
        m_mode = 0;
        if (ex_branch_taken) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        else if (is_load_use()) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end
    end
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic eval();
    #2;
    predict();
    chk("pc_enable", pc_enable, e_pc);
    chk("if_id_enable", if_id_enable, e_ifid);
    chk("if_id_flush", if_id_flush, e_flush);
    chk("id_ex_enable", id_ex_enable, e_idex);
    chk("cu_bubble", cu_bubble, e_bub);
    chk("ex_mem_enable", ex_mem_enable, e_exmem);
    chk("mem_wb_bubble", mem_wb_bubble, e_mwb);
    chk("fwd_a", fwd_a, e_fa);
    chk("fwd_b", fwd_b, e_fb);
    chk("mem_timeout", mem_timeout, m_to);
    chk("stall_count", stall_count, m_stall);
    chk("flush_count", flush_count, m_flush);
  endtask

  task automatic adv();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic clear_inputs();
    {id_ra1, id_ra2, ex_ra1, ex_ra2} = '0;
    ex_wa = 4'd0; mem_wa = 4'd0; wb_wa = 4'd0;
    {id_use_ra1, id_use_ra2, ex_reg_write, ex_mem_to_reg} = '0;
    {ex_branch_taken, mem_reg_write, wb_reg_write, dmem_busy} = '0;
  endtask

  task automatic set_load_use();
    ex_wa = 4'd2; ex_mem_to_reg = 1; ex_reg_write = 1;
    id_ra1 = 4'd2; id_use_ra1 = 1;
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    model_reset();
    // Reset values and combinational defaults.
    eval();
    chk("rst_pc", pc_enable, 1);
    chk("rst_stall", stall_count, 0);
    adv();
    reset = 1;

    // Load-use: one bubble then normal flow.
    set_load_use();
    eval();
    chk("lu_pc", pc_enable, 0);
    chk("lu_ifid", if_id_enable, 0);
    chk("lu_bubble", cu_bubble, 1);
    chk("lu_idex", id_ex_enable, 1);
    adv();
    clear_inputs();
    eval();
    chk("lu_after_pc", pc_enable, 1);
    chk("lu_stall_cnt", stall_count, 1);

    // Forwarding priority and R15 exclusion.
    mem_wa = 4'd5; wb_wa = 4'd5; mem_reg_write = 1; wb_reg_write = 1; ex_ra1 = 4'd5;
    eval();
    chk("fwd_mem", fwd_a, 2'b10);
    mem_reg_write = 0;
    eval();
    chk("fwd_wb", fwd_a, 2'b01);
    mem_wa = 4'd15; mem_reg_write = 1; wb_reg_write = 0; ex_ra2 = 4'd15;
    eval();
    chk("fwd_r15", fwd_b, 2'b00);
    adv();

    // Branch and load-use together: branch wins.
    clear_inputs();
    set_load_use();
    ex_branch_taken = 1;
    eval();
    chk("br_flush", if_id_flush, 1);
    chk("br_bubble", cu_bubble, 1);
    chk("br_pc", pc_enable, 1);
    adv();
    clear_inputs();
    eval();
    chk("br_flush_cnt", flush_count, 1);
    chk("br_stall_cnt", stall_count, 1);

    // Busy for three cycles with a pending branch, flush on the fourth.
    dmem_busy = 1; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("busy_mwb", mem_wb_bubble, 1);
      chk("busy_pc", pc_enable, 0);
      chk("busy_noflush", if_id_flush, 0);
      adv();
    end
    dmem_busy = 0;
    eval();
    chk("busy_then_flush", if_id_flush, 1);
    chk("busy_stall_cnt", stall_count, 4);
    adv();
    clear_inputs();
    eval();
    chk("busy_flush_cnt", flush_count, 2);

    // Watchdog: four busy edges trip it, then it sticks until reset.
    dmem_busy = 1;
    for (int i = 0; i < TMO; i++) begin
      eval();
      chk("wd_early", mem_timeout, 0);
      adv();
    end
    dmem_busy = 0;
    eval();
    chk("wd_set", mem_timeout, 1);
    chk("wd_frozen", pc_enable, 0);
    chk("wd_stall_cnt", stall_count, 8);
    adv();
    eval();
    chk("wd_counters_hold", stall_count, 8);
    reset = 0;
    eval();
    chk("wd_rst_clear", mem_timeout, 0);
    chk("wd_rst_pc", pc_enable, 1);
    chk("wd_rst_stall", stall_count, 0);
    adv();
    reset = 1;

    // Stall counter saturation.
    set_load_use();
    for (int i = 0; i < CMAX - 1; i++) adv();
    eval();
    chk("sat_pre", stall_count, CMAX - 1);
    for (int i = 0; i < 3; i++) begin
      adv();
      eval();
      chk("sat_hold", stall_count, CMAX);
    end
    adv();

    // Randomized traffic with occasional asynchronous reset.
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 99) != 0);
      id_ra1          = 4'($urandom_range(0, 3)); id_ra2 = 4'($urandom_range(0, 3));
      id_use_ra1      = 1'($urandom); id_use_ra2 = 1'($urandom);
      ex_ra1          = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      ex_ra2          = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      ex_wa           = 4'($urandom_range(0, 3));
      ex_reg_write    = 1'($urandom);
      ex_mem_to_reg   = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      mem_wa          = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      wb_wa           = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      mem_reg_write   = 1'($urandom);
      wb_reg_write    = 1'($urandom);
      dmem_busy       = ($urandom_range(0, 3) == 0);
      eval();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central sequencer for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB).
- Decides each cycle whether every pipeline register advances, holds, or is squashed; drives the control-unit mux bubble select.
- Generates EX-stage forwarding selects and keeps stall/flush statistics.
- Owns a data-memory wait state machine with a timeout watchdog.

Parameters:
MEM_TIMEOUT, 16, consecutive dmem_busy cycles tolerated; the count reaching this value forces TIMEOUT.
CNT_W, 16, width of the stall and flush statistics counters.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
id_ra1  in  4  ID-stage Rn, IF_ID instruction [19:16]
id_ra2  in  4  ID-stage Rm, IF_ID instruction [3:0]
id_use_ra1  in  1  ID instruction reads Rn
id_use_ra2  in  1  ID instruction reads Rm
ex_ra1  in  4  Rn held in ID/EX
ex_ra2  in  4  Rm held in ID/EX
ex_wa  in  4  ID/EX write address
ex_reg_write  in  1  ID/EX RegWrite
ex_mem_to_reg  in  1  ID/EX MemtoReg (load in EX)
ex_branch_taken  in  1  branch resolved taken in EX
mem_wa  in  4  EX/MEM write address
mem_reg_write  in  1  EX/MEM RegWrite
wb_wa  in  4  MEM/WB write address
wb_reg_write  in  1  MEM/WB RegWrite
dmem_busy  in  1  data memory not ready this cycle
pc_enable  out  1  PC register load enable
if_id_enable  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID loads NOP (all-zero instruction)
id_ex_enable  out  1  ID/EX load enable
cu_bubble  out  1  cu_mux selects all-zero controls into ID/EX
ex_mem_enable  out  1  EX/MEM load enable
mem_wb_bubble  out  1  MEM/WB loads RegWrite=0
fwd_a  out  2  ALU operand A select: 00 = register file, 01 = WB, 10 = MEM
fwd_b  out  2  same encoding for operand B
mem_timeout  out  1  sticky watchdog flag
stall_count  out  CNT_W  load-use plus memory-wait stall cycles
flush_count  out  CNT_W  taken-branch flushes

Behaviour:
- Reset values (reset=0, asynchronous): state=RUN, wait_cnt=0, mem_timeout=0, stall_count=0, flush_count=0.
- Combinational outputs during reset: all enables 1, if_id_flush=0, cu_bubble=0, mem_wb_bubble=0, fwd_a=fwd_b=00.
- States: RUN, MEM_WAIT, TIMEOUT. Stall, flush and bubble outputs are combinational from the current state and inputs (zero-cycle response). State, wait_cnt, flags and counters are registered on the rising clk edge.
- Forwarding (all states):
  - fwd_a=10 if mem_reg_write and mem_wa==ex_ra1 and mem_wa!=15.
  - Otherwise fwd_a=01 if wb_reg_write and wb_wa==ex_ra1 and wb_wa!=15.
  - Otherwise fwd_a=00. fwd_b is identical using ex_ra2. MEM wins over WB.
- Condition priority in RUN: dmem_busy > ex_branch_taken > load-use > normal.
- dmem_busy (freeze):
  - pc_enable, if_id_enable, id_ex_enable and ex_mem_enable = 0; mem_wb_bubble=1.
  - Next state MEM_WAIT, wait_cnt=1, stall_count++.
  - A branch or load-use present in the same cycle is not acted on; the frozen registers re-present it later.
- Branch taken (no busy):
  - All enables 1, if_id_flush=1, cu_bubble=1; squashes the two younger instructions.
  - flush_count++. The PC loads the branch target on the same edge.
- Load-use (no busy, no branch):
  - Trigger: ex_mem_to_reg and ex_reg_write, with (id_use_ra1 and ex_wa==id_ra1) or (id_use_ra2 and ex_wa==id_ra2).
  - Response: pc_enable=0, if_id_enable=0, cu_bubble=1, id_ex_enable=1, stall_count++. Exactly one bubble results because the load moves to MEM.
  - The dependent instruction then forwards from WB.
- MEM_WAIT:
  - While dmem_busy: freeze as above, wait_cnt++, stall_count++. When wait_cnt reaches MEM_TIMEOUT: state=TIMEOUT, mem_timeout=1.
  - When dmem_busy=0: wait_cnt=0, state=RUN, and this cycle is evaluated with RUN rules.
- TIMEOUT: pipeline permanently frozen (as in busy) and mem_timeout=1 until reset. Counters do not advance.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-stall: immediate return to the reset values above. The first cycle after reset release is evaluated in RUN.

Test Plan:
- Load-use: LDR R2,[R1] in EX (ex_wa=2, ex_mem_to_reg=1); ID reads R2 via ra1 -> one cycle with pc_enable=0, if_id_enable=0, cu_bubble=1, then normal; stall_count=1.
- Forwarding: mem_wa=5 and wb_wa=5, both RegWrite, ex_ra1=5 -> fwd_a=10. Same with mem_reg_write=0 -> fwd_a=01. mem_wa=15 with ex_ra2=15 -> fwd_b=00.
- Branch plus load-use in the same cycle -> if_id_flush=1, cu_bubble=1, pc_enable=1; flush_count=1, stall_count unchanged.
- dmem_busy for 3 cycles with ex_branch_taken=1 -> 3 frozen cycles with mem_wb_bubble=1, stall_count=3; the flush occurs on the 4th cycle.
- MEM_TIMEOUT=4, dmem_busy held high -> mem_timeout=1 after the 4th busy edge and stays 1 after busy drops; reset=0 clears it and returns to RUN.
- Force stall_count to 0xFFFE, then apply 3 load-use stalls -> stall_count ends at 0xFFFF with no wrap.
